// File: rtl/snow64_instr_decoder_pkg.sv
// Shared types and constants for the Snow64 instruction decoder:
// output struct, field positions, group codes and per-group oper limits.
package PkgSnow64InstrDecoder;

   localparam int WIDTH_INSTR     = 32;
   localparam int WIDTH_IMM_OUT   = 64;
   localparam int WIDTH_REG_INDEX = 4;
   localparam int WIDTH_GROUP     = 4;
   localparam int WIDTH_OPER      = 4;
   localparam int WIDTH_IMM_IN    = 12;

   localparam int GROUP_LSB = 28;
   localparam int RA_LSB    = 24;
   localparam int RB_LSB    = 20;
   localparam int RC_LSB    = 16;
   localparam int OPER_LSB  = 12;
   localparam int IMM_LSB   = 0;

   typedef enum logic [WIDTH_GROUP-1:0] {
      GroupAluFpu   = 4'd0,
      GroupCtrlFlow = 4'd1,
      GroupLoad     = 4'd2,
      GroupStore    = 4'd3
   } Group_t;

   localparam logic [WIDTH_OPER-1:0] MAX_OPER_ALU_FPU   = 4'd13;
   localparam logic [WIDTH_OPER-1:0] MAX_OPER_CTRL_FLOW = 4'd3;
   localparam logic [WIDTH_OPER-1:0] MAX_OPER_LOAD      = 4'd10;
   localparam logic [WIDTH_OPER-1:0] MAX_OPER_STORE     = 4'd10;

   localparam logic [WIDTH_INSTR-1:0] INSTR_NOP = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [WIDTH_GROUP-1:0]     group;
      logic [WIDTH_REG_INDEX-1:0] ra_index;
      logic [WIDTH_REG_INDEX-1:0] rb_index;
      logic [WIDTH_REG_INDEX-1:0] rc_index;
      logic [WIDTH_OPER-1:0]      oper;
      logic                       nop;
      logic [WIDTH_IMM_OUT-1:0]   imm;
      logic                       illegal;
   } PortOut_InstrDecoder;

   localparam PortOut_InstrDecoder OUT_RESET = '{
      group:    '0,
      ra_index: '0,
      rb_index: '0,
      rc_index: '0,
      oper:     '0,
      nop:      1'b1,
      imm:      '0,
      illegal:  1'b0
   };

endpackage

// File: rtl/snow64_instr_decode_comb.sv
// Purely combinational decode of one instruction word into the output struct.
module snow64_instr_decode_comb
   import PkgSnow64InstrDecoder::*;
(
   input  logic [WIDTH_INSTR-1:0] in_instr_i,
   output PortOut_InstrDecoder    out_d_o
);

   logic [WIDTH_GROUP-1:0]  grp;
   logic [WIDTH_OPER-1:0]   oper;
   logic [WIDTH_IMM_IN-1:0] imm12;
   logic                    legal;

   assign grp   = in_instr_i[GROUP_LSB +: WIDTH_GROUP];
   assign oper  = in_instr_i[OPER_LSB  +: WIDTH_OPER];
   assign imm12 = in_instr_i[IMM_LSB   +: WIDTH_IMM_IN];

   always_comb begin
      case (Group_t'(grp))
         GroupAluFpu:   legal = (oper <= MAX_OPER_ALU_FPU);
         GroupCtrlFlow: legal = (oper <= MAX_OPER_CTRL_FLOW);
         GroupLoad:     legal = (oper <= MAX_OPER_LOAD);
         GroupStore:    legal = (oper <= MAX_OPER_STORE);
         default:       legal = 1'b0;
      endcase
   end

   // The NOP word lives in group 15, so it must be recognised before the legality test.
   always_comb begin
      out_d_o = '0;
      if (in_instr_i == INSTR_NOP) begin
         out_d_o.nop = 1'b1;
      end else if (!legal) begin
         out_d_o.nop     = 1'b1;
         out_d_o.illegal = 1'b1;
      end else begin
         out_d_o.group    = grp;
         out_d_o.ra_index = in_instr_i[RA_LSB +: WIDTH_REG_INDEX];
         out_d_o.rb_index = in_instr_i[RB_LSB +: WIDTH_REG_INDEX];
         out_d_o.rc_index = in_instr_i[RC_LSB +: WIDTH_REG_INDEX];
         out_d_o.oper     = oper;
         out_d_o.imm      = {{(WIDTH_IMM_OUT-WIDTH_IMM_IN){imm12[WIDTH_IMM_IN-1]}}, imm12};
      end
   end

endmodule

// File: rtl/snow64_instr_decoder.sv
// Registered Snow64 instruction decoder: combinational decode followed by an
// async-reset output register. in_en qualifies in_instr; there is no backpressure.
module snow64_instr_decoder
   import PkgSnow64InstrDecoder::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_en,
   input  logic [WIDTH_INSTR-1:0] in_instr,
   output PortOut_InstrDecoder    out
);

   PortOut_InstrDecoder out_d;
   PortOut_InstrDecoder out_q;

   snow64_instr_decode_comb u_decode_comb (
      .in_instr_i (in_instr),
      .out_d_o    (out_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= OUT_RESET;
      end else if (in_en) begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_snow64_instr_decoder.sv
// Directed + randomized bench for snow64_instr_decoder with an expected-value queue.
module tb_snow64_instr_decoder;
   import PkgSnow64InstrDecoder::*;

   logic                clk;
   logic                rst;
   logic                in_en;
   logic [31:0]         in_instr;
   PortOut_InstrDecoder out;

   int n_checks = 0;
   int n_errors = 0;

   PortOut_InstrDecoder exp_q[$];
   PortOut_InstrDecoder last_exp;

   snow64_instr_decoder dut (
      .clk      (clk),
      .rst      (rst),
      .in_en    (in_en),
      .in_instr (in_instr),
      .out      (out)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic PortOut_InstrDecoder mk(input logic [3:0] g, input logic [3:0] ra,
                                              input logic [3:0] rb, input logic [3:0] rc,
                                              input logic [3:0] op, input logic n,
                                              input logic [63:0] im, input logic il);
      PortOut_InstrDecoder r;
      r.group = g; r.ra_index = ra; r.rb_index = rb; r.rc_index = rc;
      r.oper = op; r.nop = n; r.imm = im; r.illegal = il;
      return r;
   endfunction

   function automatic PortOut_InstrDecoder model(input logic [31:0] w);
      logic [3:0] g;
      logic [3:0] o;
      logic       ok;
      g = w[31:28];
      o = w[15:12];
      if (w == 32'hFFFF_FFFF) return mk(0, 0, 0, 0, 0, 1'b1, 64'd0, 1'b0);
      ok = (g == 4'd0 && o <= 4'd13) || (g == 4'd1 && o <= 4'd3) ||
           ((g == 4'd2 || g == 4'd3) && o <= 4'd10);
      if (!ok) return mk(0, 0, 0, 0, 0, 1'b1, 64'd0, 1'b1);
      return mk(g, w[27:24], w[23:20], w[19:16], o, 1'b0, {{52{w[11]}}, w[11:0]}, 1'b0);
   endfunction

   task automatic check(input string tag, input PortOut_InstrDecoder obs,
                        input PortOut_InstrDecoder exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver: apply one cycle of stimulus, scoreboard the given expectation
   task automatic step_exp(input string tag, input logic en, input logic [31:0] w,
                           input PortOut_InstrDecoder exp);
      PortOut_InstrDecoder e;
      @(negedge clk);
      in_en    = en;
      in_instr = w;
      exp_q.push_back(exp);
      last_exp = exp;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         check(tag, out, e);
      end
   endtask

   task automatic step(input string tag, input logic en, input logic [31:0] w);
      step_exp(tag, en, w, en ? model(w) : last_exp);
   endtask

   initial begin
      rst      = 1'b1;
      in_en    = 1'b0;
      in_instr = 32'd0;
      last_exp = OUT_RESET;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", out, OUT_RESET);
      @(negedge clk);
      rst = 1'b0;

      step_exp("alu_legal", 1'b1, 32'h0123_5FFF,
               mk(4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0));

      // async reset between edges, with in_en high across a reset edge
      @(negedge clk);
      in_en    = 1'b1;
      in_instr = 32'h2ABC_A7FF;
      #2 rst = 1'b1;
      #1 check("reset_async", out, OUT_RESET);
      @(posedge clk);
      #1 check("reset_wins_en", out, OUT_RESET);
      @(negedge clk);
      rst   = 1'b0;
      in_en = 1'b0;
      last_exp = OUT_RESET;
      step("reset_hold_no_en", 1'b0, 32'h2ABC_A7FF);

      step_exp("load_7ff", 1'b1, 32'h2ABC_A7FF,
               mk(4'd2, 4'hA, 4'hB, 4'hC, 4'd10, 1'b0, 64'h0000_0000_0000_07FF, 1'b0));
      step_exp("store_800", 1'b1, 32'h3456_A800,
               mk(4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 1'b0, 64'hFFFF_FFFF_FFFF_F800, 1'b0));
      step_exp("illegal_alu_op14", 1'b1, 32'h0000_E000, mk(0, 0, 0, 0, 0, 1'b1, 64'd0, 1'b1));
      step_exp("illegal_ctrl_op4", 1'b1, 32'h1000_4000, mk(0, 0, 0, 0, 0, 1'b1, 64'd0, 1'b1));
      step_exp("illegal_group7",   1'b1, 32'h7123_1000, mk(0, 0, 0, 0, 0, 1'b1, 64'd0, 1'b1));
      step_exp("nop_encoding",     1'b1, 32'hFFFF_FFFF, mk(0, 0, 0, 0, 0, 1'b1, 64'd0, 1'b0));
      step_exp("alu_op13_edge", 1'b1, 32'h0000_D000, mk(0, 0, 0, 0, 4'd13, 1'b0, 64'd0, 1'b0));
      step_exp("store_op11_ill", 1'b1, 32'h3000_B000, mk(0, 0, 0, 0, 0, 1'b1, 64'd0, 1'b1));

      // enable hold
      step_exp("hold_load", 1'b1, 32'h1100_3010,
               mk(4'd1, 4'd1, 4'd0, 4'd0, 4'd3, 1'b0, 64'd16, 1'b0));
      for (int i = 0; i < 3; i++) begin
         step_exp("hold_no_en", 1'b0, 32'h0FFF_0000,
                  mk(4'd1, 4'd1, 4'd0, 4'd0, 4'd3, 1'b0, 64'd16, 1'b0));
      end
      step_exp("hold_release_idx15", 1'b1, 32'h0FFF_0000,
               mk(4'd0, 4'hF, 4'hF, 4'hF, 4'd0, 1'b0, 64'd0, 1'b0));

      // back-to-back randomized words, mostly in legal groups
      for (int i = 0; i < 40; i++) begin
         logic [31:0] w;
         w = $urandom;
         w[31:28] = 4'($urandom_range(0, 5));
         step("b2b_random", 1'b1, w);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
